// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial byte receiver.
// The PARITY state and parity helper exist only when SERIAL_RX_PARITY_EN is defined.
package serial_rx_pkg;

    localparam int MIN_CLKS_PER_BIT = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } rx_state_e;

`ifdef SERIAL_RX_PARITY_EN
    // Parity bit value that makes the total number of ones (data + parity) even.
    function automatic logic evenParityBit(input logic [7:0] bits);
        return ^bits;
    endfunction
`endif

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous serial line.
// It resets to 1 so an idle line never looks like a start bit.
module rx_synchronizer (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic data_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/serial_byte_receiver.sv
// 8N1 serial byte receiver, LSB first, mid-bit sampling with a restartable bit counter.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between bit 7 and the stop bit.
module serial_byte_receiver
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clock_in,
    input  logic       reset_N,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       frame_err_out,
    output logic       busy_out
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < MIN_CLKS_PER_BIT || (CLKS_PER_BIT % 2) != 0) begin : gBadClksPerBit
        $error("CLKS_PER_BIT must be an even integer of at least 4");
    end

    logic rxS;

    rx_synchronizer uSync (
        .clk_i  (clock_in),
        .rst_ni (reset_N),
        .data_i (rx_in),
        .sync_o (rxS)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             parErr_q, parErr_d;

    always_ff @(posedge clock_in or negedge reset_N) begin
        if (!reset_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            parErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            parErr_q <= parErr_d;
        end
    end

    // The counter is held at 0 outside the timed states and cleared at every sample point.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        parErr_d = parErr_q;

        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                parErr_d = 1'b0;
                if (!rxS) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = rxS ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    shift_d  = {rxS, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d    = '0;
                    parErr_d = (rxS != evenParityBit(shift_q));
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxS && !parErr_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = rxS ? IDLE : WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rxS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign frame_err_out = err_q;
    assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Self-checking bench for serial_byte_receiver: directed frames plus random frames against a
// frame-level reference model that predicts strobe cycles, data_out and busy_out checkpoints.
module tb_serial_byte_receiver;

    localparam int C = 16;
    localparam int H = C / 2;
`ifdef SERIAL_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Line fall -> 2 sync cycles -> half bit -> remaining bits -> registered strobe.
    localparam int LAT = 2 + H + (NBITS - 1) * C + 1;

    logic       clock = 1'b0;
    logic       reset_N;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_err_out;
    logic       busy_out;

    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;

    logic [7:0] modelData = 8'h00;
    logic [7:0] expValid [int];
    bit         expErr   [int];
    bit         expBusy  [int];
    bit         monExpV;
    bit         monExpE;

    serial_byte_receiver #(.CLKS_PER_BIT(C)) dut (
        .clock_in      (clock),
        .reset_N       (reset_N),
        .rx_in         (rx_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .frame_err_out (frame_err_out),
        .busy_out      (busy_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
        end
    endtask

    function automatic logic goodPar(input logic [7:0] d);
        return ^d;
    endfunction

    // Reference model: strobes every cycle, data on strobes, busy/data at scheduled checkpoints.
    always @(negedge clock) begin
        if (!reset_N) modelData = 8'h00;
        monExpV = expValid.exists(cyc);
        monExpE = expErr.exists(cyc);
        if (monExpV) modelData = expValid[cyc];
        checkOutput("strobes", {30'd0, valid_out, frame_err_out}, {30'd0, monExpV, monExpE});
        if (monExpV || valid_out) checkOutput("dataOnValid", {24'd0, data_out}, {24'd0, modelData});
        if (expBusy.exists(cyc)) begin
            checkOutput("busy", {31'd0, busy_out}, {31'd0, expBusy[cyc]});
            checkOutput("dataHeld", {24'd0, data_out}, {24'd0, modelData});
        end
    end

    task automatic sendBit(input logic b);
        rx_in = b;
        repeat (C) @(posedge clock);
        #1;
    endtask

    task automatic idleBits(input int n);
        repeat (n) sendBit(1'b1);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input logic parBit);
        int   c0;
        logic parOk;
        c0 = cyc;
`ifdef SERIAL_RX_PARITY_EN
        parOk = (parBit == goodPar(d));
`else
        parOk = 1'b1;
`endif
        expBusy[c0 + LAT - 1] = 1'b1;
        if (stopBit && parOk) begin
            expValid[c0 + LAT]    = d;
            expBusy[c0 + LAT + 1] = 1'b0;
        end else begin
            expErr[c0 + LAT]      = 1'b1;
            expBusy[c0 + LAT + 1] = !stopBit;
        end
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        sendBit(parBit);
`endif
        sendBit(stopBit);
    endtask

    initial begin
        int         g0;
        int         r;
        int         gap;
        logic [7:0] partial;
        logic [7:0] d;
        logic       stopBit;
        logic       parBit;

        rx_in   = 1'b1;
        reset_N = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("resetData", {24'd0, data_out}, 32'h0);
        checkOutput("resetValid", {31'd0, valid_out}, 32'h0);
        checkOutput("resetErr", {31'd0, frame_err_out}, 32'h0);
        checkOutput("resetBusy", {31'd0, busy_out}, 32'h0);
        @(posedge clock);
        #1 reset_N = 1'b1;
        idleBits(4);

        applyStimulus(8'hA5, 1'b1, goodPar(8'hA5));
        idleBits(2);

        // Short low glitch: START rejects it at the half-bit sample.
        g0 = cyc;
        expBusy[g0 + 5]  = 1'b1;
        expBusy[g0 + 11] = 1'b0;
        rx_in = 1'b0;
        repeat (4) @(posedge clock);
        #1 rx_in = 1'b1;
        idleBits(2);
        checkOutput("glitchData", {24'd0, data_out}, {24'd0, modelData});

        // Bad stop bit followed by a long break: one error, busy until the line rises.
        applyStimulus(8'h3C, 1'b0, goodPar(8'h3C));
        expBusy[cyc + 20 * C] = 1'b1;
        repeat (40) sendBit(1'b0);
        r = cyc;
        expBusy[r + 1] = 1'b1;
        expBusy[r + 4] = 1'b0;
        idleBits(2);
        checkOutput("breakData", {24'd0, data_out}, {24'd0, modelData});

        applyStimulus(8'h00, 1'b1, goodPar(8'h00));
        applyStimulus(8'hFF, 1'b1, goodPar(8'hFF));
        applyStimulus(8'h81, 1'b1, goodPar(8'h81));
        idleBits(2);

        // Reset in the middle of bit 4 of 0x55; the frame is then abandoned.
        partial = 8'h55;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(partial[i]);
        rx_in = partial[4];
        repeat (8) @(posedge clock);
        #1 reset_N = 1'b0;
        @(negedge clock);
        checkOutput("busyInReset", {31'd0, busy_out}, 32'h0);
        checkOutput("dataInReset", {24'd0, data_out}, 32'h0);
        @(posedge clock);
        #1 reset_N = 1'b1;
        repeat (7) @(posedge clock);
        #1;
        idleBits(4);
        checkOutput("dataAfterReset", {24'd0, data_out}, 32'h0);
        applyStimulus(8'h12, 1'b1, goodPar(8'h12));
        idleBits(2);

`ifdef SERIAL_RX_PARITY_EN
        applyStimulus(8'h07, 1'b1, 1'b0);
        idleBits(2);
        applyStimulus(8'h07, 1'b1, 1'b1);
        idleBits(2);
`endif

        for (int k = 0; k < 16; k++) begin
            d       = 8'($urandom);
            stopBit = ($urandom_range(0, 3) != 0);
            parBit  = goodPar(d) ^ ($urandom_range(0, 4) == 0);
            gap     = $urandom_range(0, 2);
            if (!stopBit && gap == 0) gap = 1;
            applyStimulus(d, stopBit, parBit);
            idleBits(gap);
        end

        idleBits(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_byte_receiver.md
SERIAL_BYTE_RECEIVER -- requirements
Module: serial_byte_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal values are even integers of at least 4.
REQ-002 SHALL have port clock_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rx_in, input, 1 bit: asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-005 SHALL have port data_out, output, 8 bits: last correctly framed byte; feeds memory_programmer data_in.
REQ-006 SHALL have port valid_out, output, 1 bit: one-cycle strobe when data_out is updated.
REQ-007 SHALL have port frame_err_out, output, 1 bit: one-cycle strobe on a bad stop bit (or a bad parity bit, see REQ-024).
REQ-008 SHALL have port busy_out, output, 1 bit: high in every state except IDLE.

Function
REQ-009 SHALL pass rx_in through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-010 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH, plus PARITY when the macro in REQ-023 is defined.
REQ-011 SHALL move IDLE->START in the cycle after rx_s is first seen low; call that first-low cycle T.
REQ-012 SHALL sample rx_s at T+CLKS_PER_BIT/2: if high, glitch, return to IDLE with no strobe; if low, go to DATA.
REQ-013 SHALL sample data bit i (i=0..7) at T+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT, shifting into bit i of a shift register (LSB first).
REQ-014 SHALL sample the stop bit one CLKS_PER_BIT after bit 7, or after the parity bit when parity is enabled.
REQ-015 SHALL, when the stop bit is 1, load data_out from the shift register and raise valid_out for exactly the next cycle, then return to IDLE.
REQ-016 SHALL, when the stop bit is 0, leave data_out unchanged, raise frame_err_out for exactly the next cycle, and enter WAIT_HIGH.
REQ-017 SHALL hold WAIT_HIGH until rx_s is high, then return to IDLE; a held-low break therefore produces only one error.
REQ-018 SHALL size the bit-timing counter as $clog2(CLKS_PER_BIT) bits and restart it from 0 at every sample point; it never wraps free-running.
REQ-019 SHALL never assert valid_out and frame_err_out in the same cycle.
REQ-020 SHALL accept a new start bit in the first IDLE cycle, so back-to-back frames are received with zero idle bits.

Reset
REQ-021 SHALL, while reset_N is low, force state=IDLE, synchronizer flops=1, counter=0, shift register=0x00, data_out=0x00, and valid_out, frame_err_out and busy_out=0.
REQ-022 SHALL, when reset asserts mid-frame, discard the partial byte; the first frame after release must begin with a fresh falling edge.

Configuration
REQ-023 SHALL compile in even-parity checking when macro SERIAL_RX_PARITY_EN is defined: a PARITY state samples one bit between bit 7 and the stop bit.
REQ-024 SHALL, with SERIAL_RX_PARITY_EN defined, treat a parity mismatch like a bad stop bit: no data_out update, a frame_err_out strobe, and behaviour per REQ-016/017 according to the stop bit.
REQ-025 SHALL, without SERIAL_RX_PARITY_EN, use 8N1 framing with no PARITY state and no parity logic.

Structure
REQ-026 SHALL place the state enum typedef and constant MIN_CLKS_PER_BIT=4 in shared package serial_rx_pkg.
REQ-027 SHALL implement the 2-flop synchronizer as sub-module rx_synchronizer (reset value 1).

Verification (CLKS_PER_BIT=16, parity off unless stated)
REQ-028 SHALL verify: frame 0xA5 after a falling edge at cycle 0 -> valid_out high only at cycle 155, data_out=0xA5, busy_out low at cycle 156.
REQ-029 SHALL verify: a 4-cycle low glitch on idle rx_in -> no strobe, busy_out back low within 11 cycles, data_out unchanged.
REQ-030 SHALL verify: frame 0x3C with stop bit 0, then line held low for 40 bit times -> a single frame_err_out pulse, data_out unchanged, busy_out high until rx_in rises.
REQ-031 SHALL verify: back-to-back frames 0x00, 0xFF, 0x81 with no idle bits -> three valid_out pulses exactly 160 cycles apart, with matching data_out.
REQ-032 SHALL verify: reset_N pulsed low during bit 4 of 0x55, then frame 0x12 -> no strobe for 0x55, data_out=0x00, then one valid_out with 0x12.
REQ-033 SHALL verify: with SERIAL_RX_PARITY_EN defined, 0x07 sent with parity 0 -> frame_err_out pulse; 0x07 sent with parity 1 -> valid_out with data_out=0x07.
